// File: rtl/ddr4_cmd_pkg.sv
// Shared types and constants for the DDR4 command-pin phase packer.
// Holds the command codes, the pin encoding table and the tap sequencer state enum.
package ddr4_cmd_pkg;

    localparam int unsigned CMD_TYPE_W  = 3;
    localparam int unsigned PHASE_W     = 2;
    localparam int unsigned GEAR        = 4;
    localparam int unsigned TAP_STEPS_W = 8;

    localparam logic [CMD_TYPE_W-1:0] CMD_DES = 3'd0;
    localparam logic [CMD_TYPE_W-1:0] CMD_ACT = 3'd1;
    localparam logic [CMD_TYPE_W-1:0] CMD_RD  = 3'd2;
    localparam logic [CMD_TYPE_W-1:0] CMD_WR  = 3'd3;
    localparam logic [CMD_TYPE_W-1:0] CMD_PRE = 3'd4;
    localparam logic [CMD_TYPE_W-1:0] CMD_REF = 3'd5;
    localparam logic [CMD_TYPE_W-1:0] CMD_MRS = 3'd6;
    localparam logic [CMD_TYPE_W-1:0] CMD_ZQC = 3'd7;

    typedef struct packed {
        logic cs_n;
        logic act_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } cmd_pins_t;

    // {CS_N, ACT_N, RAS_N, CAS_N, WE_N} indexed by command code; ACT drives RAS/CAS/WE high
    localparam logic [7:0][4:0] CMD_ENC_TABLE = {
        5'b01110,   // ZQC
        5'b01000,   // MRS
        5'b01001,   // REF
        5'b01010,   // PRE
        5'b01100,   // WR
        5'b01101,   // RD
        5'b00111,   // ACT
        5'b11111    // DES
    };

    function automatic cmd_pins_t cmd_encode(input logic [CMD_TYPE_W-1:0] cmd_type);
        return cmd_pins_t'(CMD_ENC_TABLE[cmd_type]);
    endfunction

    typedef enum logic [2:0] {
        TAP_IDLE   = 3'd0,
        TAP_MOVE   = 3'd1,
        TAP_SETTLE = 3'd2,
        TAP_LOAD   = 3'd3,
        TAP_DONE   = 3'd4
    } tap_state_e;

endpackage

// File: rtl/ddr4_tap_stepper.sv
// Delay-line tap sequencer: issues MOVE pulses separated by settle time, or a single LOAD.
// All outputs are registered and track the state being entered.
import ddr4_cmd_pkg::*;

module ddr4_tap_stepper #(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tap_req,
    input  logic                   tap_load_req,
    input  logic                   tap_dir,
    input  logic [TAP_STEPS_W-1:0] tap_steps,
    input  logic                   out_of_range,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   dl_move,
    output logic                   dl_direction,
    output logic                   dl_load
);

    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    tap_state_e             state;
    logic [TAP_STEPS_W-1:0] step_cnt;
    logic [SET_W-1:0]       settle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= TAP_IDLE;
            step_cnt     <= '0;
            settle_cnt   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            dl_move      <= 1'b0;
            dl_direction <= 1'b0;
            dl_load      <= 1'b0;
        end else begin
            dl_move <= 1'b0;
            dl_load <= 1'b0;
            done    <= 1'b0;
            case (state)
                TAP_IDLE: begin
                    // a step request outranks a simultaneous load request
                    if (tap_req) begin
                        err          <= 1'b0;
                        busy         <= 1'b1;
                        dl_direction <= tap_dir;
                        step_cnt     <= tap_steps;
                        if (tap_steps == '0) begin
                            state <= TAP_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= TAP_MOVE;
                            dl_move <= 1'b1;
                        end
                    end else if (tap_load_req) begin
                        err          <= 1'b0;
                        busy         <= 1'b1;
                        dl_direction <= 1'b0;
                        state        <= TAP_LOAD;
                        dl_load      <= 1'b1;
                    end
                end
                TAP_MOVE: begin
                    step_cnt <= step_cnt - TAP_STEPS_W'(1);
                    if (out_of_range) begin
                        err   <= 1'b1;
                        state <= TAP_DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= TAP_SETTLE;
                        settle_cnt <= SET_W'(SETTLE_CYC - 1);
                    end
                end
                TAP_SETTLE: begin
                    if (out_of_range) begin
                        err   <= 1'b1;
                        state <= TAP_DONE;
                        done  <= 1'b1;
                    end else if (settle_cnt == '0) begin
                        if (step_cnt != '0) begin
                            state   <= TAP_MOVE;
                            dl_move <= 1'b1;
                        end else begin
                            state <= TAP_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                TAP_LOAD: begin
                    state <= TAP_DONE;
                    done  <= 1'b1;
                end
                TAP_DONE: begin
                    state        <= TAP_IDLE;
                    busy         <= 1'b0;
                    dl_direction <= 1'b0;
                end
                default: begin
                    state        <= TAP_IDLE;
                    busy         <= 1'b0;
                    dl_direction <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ddr4_cmd_phase_packer.sv
// Fabric-side DDR4 command stage: places one command per FAB_CLK into a 4:1 phase slot
// for the command-pin IODs and hosts the delay-line tap sequencer.
import ddr4_cmd_pkg::*;

module ddr4_cmd_phase_packer #(
    parameter int unsigned MIN_GAP    = 2,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                   FAB_CLK,
    input  logic                   ARST,
    input  logic                   CMD_EN,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic [CMD_TYPE_W-1:0]  CMD_TYPE,
    input  logic [PHASE_W-1:0]     CMD_PHASE,
    output logic [GEAR-1:0]        CS_N_DATA,
    output logic [GEAR-1:0]        ACT_N_DATA,
    output logic [GEAR-1:0]        RAS_N_DATA,
    output logic [GEAR-1:0]        CAS_N_DATA,
    output logic [GEAR-1:0]        WE_N_DATA,
    output logic [GEAR-1:0]        OE_DATA,
    input  logic                   TAP_REQ,
    input  logic                   TAP_LOAD_REQ,
    input  logic                   TAP_DIR,
    input  logic [TAP_STEPS_W-1:0] TAP_STEPS,
    output logic                   TAP_BUSY,
    output logic                   TAP_DONE,
    output logic                   TAP_ERR,
    output logic                   DELAY_LINE_MOVE,
    output logic                   DELAY_LINE_DIRECTION,
    output logic                   DELAY_LINE_LOAD,
    input  logic                   DELAY_LINE_OUT_OF_RANGE
);

    localparam int unsigned GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP - 1) : 1;

    logic             xfer_c;
    logic             gap_start_c;
    cmd_pins_t        enc_c;
    logic [GEAR-1:0]  slot_c;
    logic [GAP_W-1:0] gap_cnt;

    assign xfer_c      = CMD_VALID & CMD_READY;
    assign gap_start_c = xfer_c && (CMD_TYPE != CMD_DES);
    assign slot_c      = GEAR'(1) << CMD_PHASE;

    // idle cycles carry the DES pattern, which leaves every slot high
    always_comb begin
        enc_c = cmd_pins_t'('1);
        if (xfer_c) begin
            enc_c = cmd_encode(CMD_TYPE);
        end
    end

    // READY throttle: drop for MIN_GAP-1 cycles after any non-DES transfer
    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            CMD_READY <= 1'b0;
            gap_cnt   <= '0;
        end else if (gap_start_c && (MIN_GAP > 1)) begin
            CMD_READY <= 1'b0;
            gap_cnt   <= GAP_W'(MIN_GAP - 2);
        end else if (!CMD_READY) begin
            if (gap_cnt == '0) begin
                CMD_READY <= 1'b1;
            end else begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // a pin goes low only in the selected slot, and only if the encoding asks for it
    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            CS_N_DATA  <= '1;
            ACT_N_DATA <= '1;
            RAS_N_DATA <= '1;
            CAS_N_DATA <= '1;
            WE_N_DATA  <= '1;
            OE_DATA    <= '0;
        end else begin
            CS_N_DATA  <= ~(slot_c & {GEAR{~enc_c.cs_n}});
            ACT_N_DATA <= ~(slot_c & {GEAR{~enc_c.act_n}});
            RAS_N_DATA <= ~(slot_c & {GEAR{~enc_c.ras_n}});
            CAS_N_DATA <= ~(slot_c & {GEAR{~enc_c.cas_n}});
            WE_N_DATA  <= ~(slot_c & {GEAR{~enc_c.we_n}});
            OE_DATA    <= {GEAR{CMD_EN}};
        end
    end

    ddr4_tap_stepper #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_tap_stepper (
        .clk          (FAB_CLK),
        .rst          (ARST),
        .tap_req      (TAP_REQ),
        .tap_load_req (TAP_LOAD_REQ),
        .tap_dir      (TAP_DIR),
        .tap_steps    (TAP_STEPS),
        .out_of_range (DELAY_LINE_OUT_OF_RANGE),
        .busy         (TAP_BUSY),
        .done         (TAP_DONE),
        .err          (TAP_ERR),
        .dl_move      (DELAY_LINE_MOVE),
        .dl_direction (DELAY_LINE_DIRECTION),
        .dl_load      (DELAY_LINE_LOAD)
    );

endmodule

// File: tb/tb_ddr4_cmd_phase_packer.sv
// Bench for ddr4_cmd_phase_packer: fixed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a behavioural model.
module tb_ddr4_cmd_phase_packer;

    localparam int unsigned MIN_GAP    = 2;
    localparam int unsigned SETTLE_CYC = 4;

    // which command codes pull each pin low (bit n = command code n)
    localparam logic [7:0] CS_LOW  = 8'b1111_1110;
    localparam logic [7:0] ACT_LOW = 8'b0000_0010;
    localparam logic [7:0] RAS_LOW = 8'b0111_0000;
    localparam logic [7:0] CAS_LOW = 8'b0110_1100;
    localparam logic [7:0] WE_LOW  = 8'b1101_1000;

    logic       FAB_CLK = 1'b0;
    logic       ARST;
    logic       CMD_EN, CMD_VALID, CMD_READY;
    logic [2:0] CMD_TYPE;
    logic [1:0] CMD_PHASE;
    logic [3:0] CS_N_DATA, ACT_N_DATA, RAS_N_DATA, CAS_N_DATA, WE_N_DATA, OE_DATA;
    logic       TAP_REQ, TAP_LOAD_REQ, TAP_DIR;
    logic [7:0] TAP_STEPS;
    logic       TAP_BUSY, TAP_DONE, TAP_ERR;
    logic       DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, DELAY_LINE_OUT_OF_RANGE;

    int checks = 0;
    int errors = 0;
    int cyc;
    int next_ok;

    always #5 FAB_CLK = ~FAB_CLK;

    ddr4_cmd_phase_packer #(
        .MIN_GAP    (MIN_GAP),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .FAB_CLK                 (FAB_CLK),
        .ARST                    (ARST),
        .CMD_EN                  (CMD_EN),
        .CMD_VALID               (CMD_VALID),
        .CMD_READY               (CMD_READY),
        .CMD_TYPE                (CMD_TYPE),
        .CMD_PHASE               (CMD_PHASE),
        .CS_N_DATA               (CS_N_DATA),
        .ACT_N_DATA              (ACT_N_DATA),
        .RAS_N_DATA              (RAS_N_DATA),
        .CAS_N_DATA              (CAS_N_DATA),
        .WE_N_DATA               (WE_N_DATA),
        .OE_DATA                 (OE_DATA),
        .TAP_REQ                 (TAP_REQ),
        .TAP_LOAD_REQ            (TAP_LOAD_REQ),
        .TAP_DIR                 (TAP_DIR),
        .TAP_STEPS               (TAP_STEPS),
        .TAP_BUSY                (TAP_BUSY),
        .TAP_DONE                (TAP_DONE),
        .TAP_ERR                 (TAP_ERR),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE)
    );

    typedef struct {
        logic       en;
        logic       valid;
        logic [2:0] ctype;
        logic [1:0] phase;
        logic [3:0] cs, act, ras, cas, we, oe;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge FAB_CLK);
        #1;
    endtask

    function automatic logic [3:0] pin_vec(input logic [7:0] low_mask, input logic [2:0] t,
                                           input logic [1:0] ph, input logic xfer);
        logic [3:0] v;
        v = 4'hF;
        if (xfer && low_mask[t]) v[ph] = 1'b0;
        return v;
    endfunction

    function automatic logic [23:0] cmd_exp(input logic [2:0] t, input logic [1:0] ph,
                                            input logic xfer, input logic en);
        return {pin_vec(CS_LOW, t, ph, xfer), pin_vec(ACT_LOW, t, ph, xfer),
                pin_vec(RAS_LOW, t, ph, xfer), pin_vec(CAS_LOW, t, ph, xfer),
                pin_vec(WE_LOW, t, ph, xfer), {4{en}}};
    endfunction

    function automatic logic [31:0] cmd_act();
        return 32'({CS_N_DATA, ACT_N_DATA, RAS_N_DATA, CAS_N_DATA, WE_N_DATA, OE_DATA});
    endfunction

    // {busy, move, done, dir, load, err} expected k cycles after a step request
    function automatic logic [5:0] tap_exp(input int k, input int n, input logic dir);
        int   dk;
        logic busy, move, done;
        dk   = n * (SETTLE_CYC + 1) + 1;
        busy = (k >= 1) && (k <= dk);
        done = (k == dk);
        move = (k >= 1) && (k < dk) && (((k - 1) % (SETTLE_CYC + 1)) == 0);
        return {busy, move, done, busy & dir, 1'b0, 1'b0};
    endfunction

    function automatic logic [31:0] tap_act();
        return 32'({TAP_BUSY, DELAY_LINE_MOVE, TAP_DONE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, TAP_ERR});
    endfunction

    // one command cycle checked against the ready/gap model
    task automatic cmd_cycle(input logic en, input logic valid, input logic [2:0] t, input logic [1:0] ph);
        logic exp_ready, xfer;
        exp_ready = (cyc >= next_ok);
        chk("rand_ready", 32'(CMD_READY), 32'(exp_ready));
        CMD_EN = en; CMD_VALID = valid; CMD_TYPE = t; CMD_PHASE = ph;
        xfer = valid && exp_ready;
        if (xfer && t != 3'd0) next_ok = cyc + MIN_GAP;
        tick();
        cyc++;
        chk("rand_pins", cmd_act(), 32'(cmd_exp(t, ph, xfer, en)));
    endtask

    task automatic run_steps(input int n, input logic dir, input logic also_load);
        int dk;
        dk = n * (SETTLE_CYC + 1) + 1;
        TAP_REQ = 1'b1; TAP_LOAD_REQ = also_load; TAP_DIR = dir; TAP_STEPS = 8'(n);
        tick();
        TAP_REQ = 1'b0; TAP_LOAD_REQ = 1'b0; TAP_DIR = ~dir; TAP_STEPS = 8'd0;
        chk("tap_seq_k1", tap_act(), 32'(tap_exp(1, n, dir)));
        for (int k = 2; k <= dk + 2; k++) begin
            tick();
            chk("tap_seq", tap_act(), 32'(tap_exp(k, n, dir)));
        end
    endtask

    initial begin
        int moves, dones;

        vecs[0] = '{1'b1, 1'b1, 3'd2, 2'd2, 4'b1011, 4'hF, 4'hF, 4'b1011, 4'hF, 4'hF};
        vecs[1] = '{1'b1, 1'b1, 3'd1, 2'd0, 4'b1110, 4'b1110, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[2] = '{1'b0, 1'b1, 3'd3, 2'd3, 4'b0111, 4'hF, 4'hF, 4'b0111, 4'b0111, 4'h0};
        vecs[3] = '{1'b1, 1'b1, 3'd4, 2'd1, 4'b1101, 4'hF, 4'b1101, 4'hF, 4'b1101, 4'hF};
        vecs[4] = '{1'b1, 1'b1, 3'd5, 2'd3, 4'b0111, 4'hF, 4'b0111, 4'b0111, 4'hF, 4'hF};
        vecs[5] = '{1'b1, 1'b1, 3'd6, 2'd0, 4'b1110, 4'hF, 4'b1110, 4'b1110, 4'b1110, 4'hF};
        vecs[6] = '{1'b1, 1'b1, 3'd7, 2'd2, 4'b1011, 4'hF, 4'hF, 4'hF, 4'b1011, 4'hF};
        vecs[7] = '{1'b1, 1'b1, 3'd0, 2'd1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[8] = '{1'b1, 1'b0, 3'd2, 2'd0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[9] = '{1'b0, 1'b1, 3'd0, 2'd3, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};

        ARST = 1'b1;
        CMD_EN = 1'b0; CMD_VALID = 1'b0; CMD_TYPE = 3'd0; CMD_PHASE = 2'd0;
        TAP_REQ = 1'b0; TAP_LOAD_REQ = 1'b0; TAP_DIR = 1'b0; TAP_STEPS = 8'd0;
        DELAY_LINE_OUT_OF_RANGE = 1'b0;

        // reset state and READY release
        #2;
        chk("reset_pins", cmd_act(), 32'(24'hFFFFF0));
        chk("reset_ready", 32'(CMD_READY), 32'd0);
        chk("reset_tap", tap_act(), 32'd0);
        #1 ARST = 1'b0;
        #1 chk("ready_before_edge", 32'(CMD_READY), 32'd0);
        tick();
        chk("ready_after_release", 32'(CMD_READY), 32'd1);

        // fixed vector table, each followed by an idle cycle
        foreach (vecs[i]) begin
            chk("vec_ready", 32'(CMD_READY), 32'd1);
            CMD_EN = vecs[i].en; CMD_VALID = vecs[i].valid;
            CMD_TYPE = vecs[i].ctype; CMD_PHASE = vecs[i].phase;
            tick();
            chk($sformatf("vec%0d_pins", i), cmd_act(),
                32'({vecs[i].cs, vecs[i].act, vecs[i].ras, vecs[i].cas, vecs[i].we, vecs[i].oe}));
            CMD_VALID = 1'b0;
            tick();
            chk($sformatf("vec%0d_idle", i), cmd_act(), 32'({20'hFFFFF, {4{CMD_EN}}}));
        end

        // VALID held: ACT then WR accepted two cycles apart
        CMD_EN = 1'b1; CMD_VALID = 1'b1; CMD_TYPE = 3'd1; CMD_PHASE = 2'd1;
        tick();
        chk("gap_act_pins", cmd_act(), 32'(cmd_exp(3'd1, 2'd1, 1'b1, 1'b1)));
        chk("gap_ready_low", 32'(CMD_READY), 32'd0);
        CMD_TYPE = 3'd3; CMD_PHASE = 2'd3;
        tick();
        chk("gap_held_idle", cmd_act(), 32'(cmd_exp(3'd3, 2'd3, 1'b0, 1'b1)));
        chk("gap_ready_back", 32'(CMD_READY), 32'd1);
        tick();
        chk("gap_wr_pins", cmd_act(), 32'(cmd_exp(3'd3, 2'd3, 1'b1, 1'b1)));
        chk("gap_ready_low2", 32'(CMD_READY), 32'd0);
        CMD_VALID = 1'b0;
        tick();
        tick();

        // randomized traffic against the model
        cyc = 0;
        next_ok = 0;
        for (int i = 0; i < 300; i++) begin
            cmd_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                      3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        CMD_VALID = 1'b0;
        tick();

        // step sequence: 3 steps, direction up
        run_steps(3, 1'b1, 1'b0);

        // load-only sequence
        TAP_LOAD_REQ = 1'b1;
        tick();
        TAP_LOAD_REQ = 1'b0;
        chk("load_k1", tap_act(), 32'(6'b100010));
        tick();
        chk("load_k2", tap_act(), 32'(6'b101000));
        tick();
        chk("load_k3", tap_act(), 32'd0);

        // out-of-range abort after the second MOVE
        moves = 0; dones = 0;
        TAP_REQ = 1'b1; TAP_DIR = 1'b0; TAP_STEPS = 8'd10;
        tick();
        TAP_REQ = 1'b0; TAP_STEPS = 8'd0;
        if (DELAY_LINE_MOVE) moves++;
        for (int k = 2; k <= 40; k++) begin
            tick();
            if (DELAY_LINE_MOVE) moves++;
            if (TAP_DONE) begin
                dones++;
                DELAY_LINE_OUT_OF_RANGE = 1'b0;
            end else if (moves == 2 && !DELAY_LINE_MOVE && dones == 0) begin
                DELAY_LINE_OUT_OF_RANGE = 1'b1;
            end
        end
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        chk("oor_moves", 32'(moves), 32'd2);
        chk("oor_dones", 32'(dones), 32'd1);
        chk("oor_err_sticky", 32'(TAP_ERR), 32'd1);
        chk("oor_busy_end", 32'(TAP_BUSY), 32'd0);

        // next request clears the error (zero steps goes straight to DONE)
        run_steps(0, 1'b1, 1'b0);

        // asynchronous reset in the middle of SETTLE
        TAP_REQ = 1'b1; TAP_DIR = 1'b1; TAP_STEPS = 8'd5;
        CMD_EN = 1'b1;
        tick();
        TAP_REQ = 1'b0; TAP_STEPS = 8'd0;
        tick();
        tick();
        chk("pre_reset_busy", 32'(TAP_BUSY), 32'd1);
        ARST = 1'b1;
        #1;
        chk("midreset_tap", tap_act(), 32'd0);
        chk("midreset_pins", cmd_act(), 32'(24'hFFFFF0));
        chk("midreset_ready", 32'(CMD_READY), 32'd0);
        #1 ARST = 1'b0;
        tick();
        chk("postreset_ready", 32'(CMD_READY), 32'd1);
        moves = 0;
        for (int k = 0; k < 12; k++) begin
            if (DELAY_LINE_MOVE || TAP_BUSY) moves++;
            tick();
        end
        chk("postreset_quiet", 32'(moves), 32'd0);

        // simultaneous load and step request: steps win
        run_steps(1, 1'b0, 1'b1);

        // randomized step sequences
        for (int r = 0; r < 4; r++) begin
            run_steps($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
